// File: rtl/inst_mem_loader_pkg.sv
// Shared types and constants for the switch-driven instruction memory loader.
package inst_mem_loader_pkg;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_WRITE   = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

  localparam int unsigned BYTES_PER_WORD          = 4;
  localparam int unsigned BYTE_W                  = 8;
  localparam int unsigned LANE_W                  = 2;
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/inst_mem_loader_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, one-cycle press pulse
// on the rising edge of the accepted (stable) level.
module btn_debounce
  import inst_mem_loader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Raw,
  output logic Pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             pulse_q;
  logic [CNT_W-1:0] cnt_q;
  logic             differ_d;
  logic             accept_d;

  assign differ_d = (sync2_q != stable_q);
  assign accept_d = differ_d && (cnt_q == CNT_LAST);

  // Pulse is raised in the same edge that promotes a new high level to stable.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= Raw;
      sync2_q <= sync1_q;
      pulse_q <= accept_d && sync2_q;
      if (accept_d) begin
        stable_q <= sync2_q;
        cnt_q    <= '0;
      end else if (differ_d) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign Pulse = pulse_q;

endmodule

// File: rtl/inst_mem_loader.sv
// Assembles switch bytes little-endian into 32-bit words and writes them to
// sequential instruction memory addresses until memory is full.
module inst_mem_loader
  import inst_mem_loader_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned ADDR_W          = 6,
  parameter int unsigned DATA_W          = 32
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [7:0]        Sw,
  input  logic              Load_btn,
  input  logic              Flush_btn,
  output logic              Mem_we,
  output logic [ADDR_W-1:0] Mem_addr,
  output logic [DATA_W-1:0] Mem_din,
  output logic [1:0]        Byte_idx,
  output logic [ADDR_W:0]   Word_count,
  output logic              Full,
  output logic [7:0]        LED
);

  localparam logic [ADDR_W:0]   WC_MAX    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(BYTES_PER_WORD - 1);

  logic load_pulse;
  logic flush_pulse;

  state_e              state_q;
  logic [DATA_W-1:0]   acc_q;
  logic [LANE_W-1:0]   byte_idx_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W:0]     wc_q;
  logic                we_q;
  logic [DATA_W-1:0]   din_q;
  logic                full_q;
  logic [BYTE_W-1:0]   led_q;

  logic                last_lane_d;
  logic [DATA_W-1:0]   word_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
    .Clk   (Clk),
    .Rst   (Rst),
    .Raw   (Load_btn),
    .Pulse (load_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_flush_db (
    .Clk   (Clk),
    .Rst   (Rst),
    .Raw   (Flush_btn),
    .Pulse (flush_pulse)
  );

  // The final byte goes straight into the write word, bypassing the accumulator.
  assign last_lane_d = (byte_idx_q == LANE_LAST);
  assign word_d      = {Sw, acc_q[DATA_W-BYTE_W-1:0]};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_COLLECT;
      acc_q      <= '0;
      byte_idx_q <= '0;
      addr_q     <= '0;
      wc_q       <= '0;
      we_q       <= 1'b0;
      din_q      <= '0;
      full_q     <= 1'b0;
      led_q      <= '0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          // Load has priority; a coincident flush pulse is dropped.
          if (load_pulse) begin
            led_q                             <= Sw;
            acc_q[{byte_idx_q, 3'b000} +: 8] <= Sw;
            if (last_lane_d) begin
              din_q      <= word_d;
              we_q       <= 1'b1;
              byte_idx_q <= '0;
              state_q    <= ST_WRITE;
            end else begin
              byte_idx_q <= byte_idx_q + LANE_W'(1);
            end
          end else if (flush_pulse && (byte_idx_q != '0)) begin
            din_q      <= acc_q;
            we_q       <= 1'b1;
            byte_idx_q <= '0;
            state_q    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          we_q   <= 1'b0;
          acc_q  <= '0;
          addr_q <= addr_q + ADDR_W'(1);
          if (wc_q != WC_MAX) begin
            wc_q <= wc_q + (ADDR_W+1)'(1);
          end
          if (addr_q == ADDR_LAST) begin
            full_q  <= 1'b1;
            state_q <= ST_FULL;
          end else begin
            state_q <= ST_COLLECT;
          end
        end
        ST_FULL: begin
          state_q <= ST_FULL;
        end
        default: begin
          state_q <= ST_COLLECT;
        end
      endcase
    end
  end

  assign Mem_we     = we_q;
  assign Mem_addr   = addr_q;
  assign Mem_din    = din_q;
  assign Byte_idx   = byte_idx_q;
  assign Word_count = wc_q;
  assign Full       = full_q;
  assign LED        = led_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized scoreboard bench for inst_mem_loader: a byte-list reference model
// predicts memory writes, a monitor checks every Mem_we strobe against them.
module tb_inst_mem_loader;

  localparam int unsigned DC = 4;
  localparam int unsigned AW = 6;
  localparam int unsigned DW = 32;
  localparam int          NWORDS = 1 << AW;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [7:0]    Sw;
  logic          Load_btn;
  logic          Flush_btn;
  logic          Mem_we;
  logic [AW-1:0] Mem_addr;
  logic [DW-1:0] Mem_din;
  logic [1:0]    Byte_idx;
  logic [AW:0]   Word_count;
  logic          Full;
  logic [7:0]    LED;

  always #5 Clk = ~Clk;

  inst_mem_loader #(.DEBOUNCE_CYCLES(DC), .ADDR_W(AW), .DATA_W(DW)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Sw         (Sw),
    .Load_btn   (Load_btn),
    .Flush_btn  (Flush_btn),
    .Mem_we     (Mem_we),
    .Mem_addr   (Mem_addr),
    .Mem_din    (Mem_din),
    .Byte_idx   (Byte_idx),
    .Word_count (Word_count),
    .Full       (Full),
    .LED        (LED)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: bytes of the word in progress plus memory-level counters.
  logic [7:0] m_bytes[$];
  logic [7:0] m_led;
  int         m_addr;
  int         m_wc;
  bit         m_full;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic void m_reset();
    m_bytes.delete();
    m_led  = 8'h00;
    m_addr = 0;
    m_wc   = 0;
    m_full = 1'b0;
  endfunction

  function automatic void m_commit();
    wr_t e;
    e.addr = AW'(m_addr);
    e.data = '0;
    foreach (m_bytes[i]) e.data[8*i +: 8] = m_bytes[i];
    exp_q.push_back(e);
    m_bytes.delete();
    m_wc++;
    m_addr = (m_addr + 1) % NWORDS;
    if (m_addr == 0) m_full = 1'b1;
  endfunction

  function automatic void m_load(input logic [7:0] v);
    if (m_full) return;
    m_led = v;
    m_bytes.push_back(v);
    if (m_bytes.size() == 4) m_commit();
  endfunction

  function automatic void m_flush();
    if (!m_full && m_bytes.size() > 0) m_commit();
  endfunction

  // Monitor: every write strobe must match the oldest predicted write.
  always @(negedge Clk) begin
    if (Mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr %0d data %h, expected no write", Mem_addr, Mem_din);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(Mem_addr), 64'(e.addr));
        check("wr_data", 64'(Mem_din), 64'(e.data));
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_led"},   64'(LED),        64'(m_led));
    check({tag, "_idx"},   64'(Byte_idx),   64'(m_bytes.size()));
    check({tag, "_addr"},  64'(Mem_addr),   64'(m_addr));
    check({tag, "_wc"},    64'(Word_count), 64'(m_wc));
    check({tag, "_full"},  64'(Full),       64'(m_full));
    check({tag, "_we"},    64'(Mem_we),     64'(0));
  endtask

  task automatic do_reset();
    check("pending_before_reset", 64'(exp_q.size()), 64'(0));
    Rst = 1'b1;
    Load_btn = 1'b0;
    Flush_btn = 1'b0;
    @(negedge Clk);
    check("rst_we",   64'(Mem_we),     64'(0));
    check("rst_addr", 64'(Mem_addr),   64'(0));
    check("rst_din",  64'(Mem_din),    64'(0));
    check("rst_idx",  64'(Byte_idx),   64'(0));
    check("rst_wc",   64'(Word_count), 64'(0));
    check("rst_full", 64'(Full),       64'(0));
    check("rst_led",  64'(LED),        64'(0));
    Rst = 1'b0;
    m_reset();
  endtask

  // Press issued at a negedge; prediction is queued before the DUT can respond.
  task automatic press(input bit ld, input bit fl, input logic [7:0] v, input int hold);
    Sw = v;
    if (ld) m_load(v);
    else if (fl) m_flush();
    Load_btn  = ld;
    Flush_btn = fl;
    wait_cycles(hold);
    Load_btn  = 1'b0;
    Flush_btn = 1'b0;
    wait_cycles(DC + 6);
  endtask

  task automatic glitch(input int g);
    Load_btn = 1'b1;
    wait_cycles(g);
    Load_btn = 1'b0;
    wait_cycles(DC + 4);
  endtask

  initial begin
    int lat;
    int r;
    Rst = 1'b1;
    Sw = 8'h00;
    Load_btn = 1'b0;
    Flush_btn = 1'b0;
    m_reset();
    wait_cycles(2);
    do_reset();

    // Single clean press: latency from raw edge to LED update.
    Sw = 8'hA5;
    m_load(8'hA5);
    Load_btn = 1'b1;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge Clk);
      if (LED == 8'hA5) begin
        lat = k;
        break;
      end
    end
    check("load_latency", 64'(lat), 64'(DC + 3));
    check_state("t1");
    wait_cycles((lat > 0 && lat < 10) ? 10 - lat : 1);
    Load_btn = 1'b0;
    wait_cycles(DC + 6);
    check_state("t1_after");

    // One full word.
    do_reset();
    press(1, 0, 8'h13, 6);
    press(1, 0, 8'h00, 6);
    press(1, 0, 8'h10, 6);
    press(1, 0, 8'h20, 6);
    check_state("t2");

    // Short glitches rejected.
    do_reset();
    glitch(1);
    glitch(2);
    glitch(3);
    press(1, 0, 8'h5A, 5);
    check_state("t3");

    // Partial-word flush, then a flush with nothing collected.
    do_reset();
    press(1, 0, 8'hEF, 5);
    press(1, 0, 8'hBE, 5);
    press(0, 1, 8'h00, 5);
    check_state("t4_flush");
    press(0, 1, 8'h77, 5);
    check_state("t4_empty_flush");

    // Random mix of loads, flushes, glitches and simultaneous presses.
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 2) glitch(int'($urandom_range(1, DC - 1)));
      press((r != 0), (r <= 1), 8'($urandom), int'($urandom_range(DC, DC + 5)));
      check_state("rand");
    end

    // Fill the whole memory, then confirm input is ignored.
    do_reset();
    for (int i = 0; i < 4 * NWORDS; i++) press(1, 0, 8'($urandom), DC + 1);
    check_state("t5_full");
    press(1, 0, 8'h3C, DC + 2);
    press(0, 1, 8'h00, DC + 2);
    check_state("t5_ignored");

    // Reset mid-word drops the partial bytes.
    do_reset();
    press(1, 0, 8'h11, 5);
    press(1, 0, 8'h22, 5);
    press(1, 0, 8'h33, 5);
    m_bytes.delete();
    exp_q.delete();
    do_reset();
    press(1, 0, 8'h44, 5);
    press(1, 0, 8'h55, 5);
    press(1, 0, 8'h66, 5);
    press(1, 0, 8'h77, 5);
    check_state("t6");

    wait_cycles(4);
    check("exp_queue_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Write-side companion to the button-stepped instruction fetch/display path: fills instruction memory by hand from board switches.
- Each debounced Load press captures one byte from Sw. Every 4 bytes are assembled little-endian into a 32-bit word, which is written to sequential word addresses.
- Mem_we/Mem_addr/Mem_din connect directly to the write port (wea/addra/dina) of the instruction block RAM, which is clocked by Clk while loading.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable Clk cycles required before a button level is accepted; 4 for simulation, board value set at instantiation.
- ADDR_W, 6, word address width; matches PC[7:2], 64 words.
- DATA_W, 32, instruction word width; fixed at 32.

Ports:
- Clk  in  1  system clock, all logic on posedge
- Rst  in  1  reset
- Sw  in  8  byte value to enter
- Load_btn  in  1  raw, asynchronous, bouncing "enter byte" button
- Flush_btn  in  1  raw, asynchronous "commit partial word" button
- Mem_we  out  1  one-cycle write strobe to instruction memory
- Mem_addr  out  ADDR_W  word address of current/next write
- Mem_din  out  DATA_W  assembled word, valid when Mem_we=1
- Byte_idx  out  2  number of bytes collected in current word (0..3)
- Word_count  out  ADDR_W+1  words written since reset (0..64)
- Full  out  1  memory full, further input ignored
- LED  out  8  last accepted byte

Interface decision: reset Rst, synchronous, active-high.

Behaviour:
- Reset (Rst=1 at posedge):
  - All outputs become 0.
  - Word accumulator, synchronizers, debounce counters, stable levels and FSM all clear; FSM goes to COLLECT.
  - Rst mid-word discards the partial bytes; no write is issued.
- Button conditioning:
  - Each raw button passes through a 2-FF synchronizer.
  - A counter increments while the synchronized level differs from the stable level and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable level is updated.
  - A rising edge of the stable level produces a one-cycle press pulse.
  - Result: press pulse occurs DEBOUNCE_CYCLES+2 cycles after a clean rising edge of the raw input. Glitches shorter than DEBOUNCE_CYCLES produce no pulse. Release produces no pulse.
- FSM states: COLLECT, WRITE, FULL.
- COLLECT, load pulse at cycle T (Sw sampled at T):
  - At T+1: accumulator byte lane Byte_idx gets Sw (lane 0 = bits 7:0, lane 3 = bits 31:24), and LED gets Sw.
  - If the byte was lane 3: at T+1 go to WRITE, Byte_idx becomes 0.
  - Otherwise Byte_idx increments.
- COLLECT, flush pulse:
  - With Byte_idx>0: unfilled lanes are zero, go to WRITE, Byte_idx becomes 0.
  - With Byte_idx=0: no action.
- WRITE (exactly one cycle):
  - Mem_we=1; Mem_din = assembled word; Mem_addr = current address.
  - Next cycle: Mem_we=0, accumulator cleared, Word_count+1, Mem_addr+1.
  - If the write was to address 2^ADDR_W-1: Mem_addr wraps to 0, Full=1, go to FULL; otherwise return to COLLECT.
  - Any press pulse during WRITE is dropped.
- FULL:
  - All press pulses ignored; LED, Mem_* and counters hold.
  - Exit only via Rst.
- Simultaneous load and flush pulse in COLLECT: load wins, flush is dropped.
- Mem_din is held at the last written word when Mem_we=0. Memory samples only on Mem_we.
- Word_count saturates at 2^ADDR_W; it never wraps.

Decomposition:
- Shared package:
  - FSM state encoding (COLLECT=0, WRITE=1, FULL=2).
  - Byte-lane constants (BYTES_PER_WORD=4).
  - Default DEBOUNCE_CYCLES.
- One sub-module: btn_debounce (synchronizer, stable-level counter, rising-edge pulse).
  - Parameter DEBOUNCE_CYCLES; ports Clk, Rst, Raw, Pulse.
  - Instantiated twice (Load_btn, Flush_btn).

Test Plan (DEBOUNCE_CYCLES=4):
1. Clean Load press with Sw=8'hA5 held 10 cycles -> exactly one pulse, DEBOUNCE_CYCLES+2 cycles after the raw edge. Next cycle: LED=8'hA5, Byte_idx=1, Mem_we stays 0.
2. Four presses with Sw=8'h13, 8'h00, 8'h10, 8'h20 -> one Mem_we pulse, Mem_addr=0, Mem_din=32'h20100013. Afterwards Mem_addr=1, Word_count=1, Byte_idx=0.
3. Load raw toggled in 1-, 2- and 3-cycle glitches, then a stable press -> only one byte accepted (Byte_idx=1).
4. Two bytes 8'hEF, 8'hBE, then Flush press -> Mem_we with Mem_din=32'h0000BEEF. Flush press with Byte_idx=0 -> no Mem_we.
5. 256 bytes loaded -> 64 writes to addresses 0..63. Then Full=1, Word_count=64, Mem_addr=0. A further Load press changes nothing.
6. Rst=1 for one cycle after 3 bytes -> all outputs 0, no Mem_we. The next 4 bytes are written to address 0.
